// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : piso_serializer
// Purpose  : LSB-first parallel-to-serial transmitter with valid/ready load,
//            registered framing strobe, optional even parity and done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter int PARITY_EN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             sdata,
    output logic             sframe,
    output logic             done
);

    localparam int               CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    // Bit 0 goes straight to sdata on accept, so only the remaining bits are held.
    logic [WIDTH-2:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               par_q,   par_d;
    logic               sdata_q, sdata_d;
    logic               sframe_q, sframe_d;
    logic               done_q,  done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            par_q    <= 1'b0;
            sdata_q  <= 1'b0;
            sframe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            par_q    <= par_d;
            sdata_q  <= sdata_d;
            sframe_q <= sframe_d;
            done_q   <= done_d;
        end
    end

    // Serial outputs are computed for the upcoming state so they leave flops.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        par_d    = par_q;
        sdata_d  = 1'b0;
        sframe_d = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load_valid) begin
                    state_d  = S_SHIFT;
                    shift_d  = load_data[WIDTH-1:1];
                    cnt_d    = '0;
                    par_d    = ^load_data;
                    sdata_d  = load_data[0];
                    sframe_d = 1'b1;
                end
            end
            S_SHIFT: begin
                if (cnt_q == C_LAST) begin
                    if (PARITY_EN != 0) begin
                        state_d  = S_PARITY;
                        sdata_d  = par_q;
                        sframe_d = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                    sdata_d  = shift_q[0];
                    shift_d  = shift_q >> 1;
                    sframe_d = 1'b1;
                end
            end
            S_PARITY: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign load_ready = (state_q == S_IDLE) && !rst;
    assign sdata      = sdata_q;
    assign sframe     = sframe_q;
    assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_serializer
// Purpose  : Self-checking bench; instance 0 without parity, instance 1 with.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic sf;
        logic sd;
        logic dn;
        logic lr;
    } obs_t;

    logic             clk;
    logic             rst;
    logic             lv [2];
    logic [WIDTH-1:0] ld [2];
    logic             lr [2];
    logic             sd [2];
    logic             sf [2];
    logic             dn [2];

    int   n_checks = 0;
    int   n_fail   = 0;
    obs_t exp_q[$];

    piso_serializer #(.WIDTH(WIDTH), .PARITY_EN(0)) u_dut0 (
        .clk(clk), .rst(rst), .load_valid(lv[0]), .load_data(ld[0]),
        .load_ready(lr[0]), .sdata(sd[0]), .sframe(sf[0]), .done(dn[0])
    );

    piso_serializer #(.WIDTH(WIDTH), .PARITY_EN(1)) u_dut1 (
        .clk(clk), .rst(rst), .load_valid(lv[1]), .load_data(ld[1]),
        .load_ready(lr[1]), .sdata(sd[1]), .sframe(sf[1]), .done(dn[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: one entry per cycle after the accept edge, ending with the
    // IDLE cycle in which the next word may be offered.
    task automatic model_frame(input logic [WIDTH-1:0] d, input bit par);
        int ones;
        ones = 0;
        for (int i = 0; i < WIDTH; i++) begin
            exp_q.push_back('{sf: 1'b1, sd: d[i], dn: 1'b0, lr: 1'b0});
            ones += int'(d[i]);
        end
        if (par)
            exp_q.push_back('{sf: 1'b1, sd: logic'(ones % 2), dn: 1'b0, lr: 1'b0});
        exp_q.push_back('{sf: 1'b0, sd: 1'b0, dn: 1'b1, lr: 1'b0});
        exp_q.push_back('{sf: 1'b0, sd: 1'b0, dn: 1'b0, lr: 1'b1});
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            lv[k] = 1'b1;
            ld[k] = WIDTH'($urandom);
        end
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({sd[k], sf[k], dn[k], lr[k]} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_hold dut%0d: sd/sf/dn/lr=%b expected 0000", k, {sd[k], sf[k], dn[k], lr[k]});
            end
        end
        rst = 1'b0;
        lv[0] = 1'b0;
        lv[1] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if ({lr[k], sf[k], dn[k]} !== 3'b100) begin
                    n_fail++;
                    $display("FAIL reset_release dut%0d cyc%0d: lr/sf/dn=%b expected 100", k, c, {lr[k], sf[k], dn[k]});
                end
            end
        end
    endtask

    task automatic test_single_frame;
        obs_t got;
        exp_q.delete();
        model_frame(8'hA5, 1'b0);
        lv[0] = 1'b1;
        ld[0] = 8'hA5;
        @(negedge clk);
        lv[0] = 1'b0;
        foreach (exp_q[i]) begin
            got = {sf[0], sd[0], dn[0], lr[0]};
            n_checks++;
            if (got !== exp_q[i]) begin
                n_fail++;
                $display("FAIL single_frame[%0d]: sf/sd/dn/lr=%b expected %b", i, got, exp_q[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_parity;
        obs_t             got;
        logic [WIDTH-1:0] words [2];
        words[0] = 8'h07;
        words[1] = 8'hA5;
        for (int w = 0; w < 2; w++) begin
            exp_q.delete();
            model_frame(words[w], 1'b1);
            lv[1] = 1'b1;
            ld[1] = words[w];
            @(negedge clk);
            lv[1] = 1'b0;
            foreach (exp_q[i]) begin
                got = {sf[1], sd[1], dn[1], lr[1]};
                n_checks++;
                if (got !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL parity w%0h[%0d]: sf/sd/dn/lr=%b expected %b", words[w], i, got, exp_q[i]);
                end
                @(negedge clk);
            end
        end
    endtask

    // load_valid stays high and load_data churns; only IDLE may accept.
    task automatic test_busy;
        obs_t             got;
        logic [WIDTH-1:0] second;
        int               frames;
        second = WIDTH'($urandom);
        exp_q.delete();
        model_frame(8'h3C, 1'b0);
        model_frame(second, 1'b0);
        lv[0] = 1'b1;
        ld[0] = 8'h3C;
        frames = 0;
        @(negedge clk);
        foreach (exp_q[i]) begin
            got = {sf[0], sd[0], dn[0], lr[0]};
            n_checks++;
            if (got !== exp_q[i]) begin
                n_fail++;
                $display("FAIL busy[%0d]: sf/sd/dn/lr=%b expected %b", i, got, exp_q[i]);
            end
            if (exp_q[i].lr) begin
                frames++;
                if (frames == 1) ld[0] = second;
                else             lv[0] = 1'b0;
            end else begin
                ld[0] = WIDTH'($urandom);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midframe;
        obs_t got;
        lv[0] = 1'b1;
        ld[0] = 8'hFF;
        @(negedge clk);
        lv[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({sf[0], sd[0]} !== 2'b11) begin
                n_fail++;
                $display("FAIL midframe_bit%0d: sf/sd=%b expected 11", i, {sf[0], sd[0]});
            end
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({sf[0], sd[0], dn[0]} !== 3'b000) begin
            n_fail++;
            $display("FAIL midframe_async: sf/sd/dn=%b expected 000", {sf[0], sd[0], dn[0]});
        end
        @(negedge clk);
        n_checks++;
        if ({dn[0], lr[0]} !== 2'b00) begin
            n_fail++;
            $display("FAIL midframe_inrst: dn/lr=%b expected 00", {dn[0], lr[0]});
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({sf[0], dn[0], lr[0]} !== 3'b001) begin
            n_fail++;
            $display("FAIL midframe_release: sf/dn/lr=%b expected 001", {sf[0], dn[0], lr[0]});
        end
        exp_q.delete();
        model_frame(8'h01, 1'b0);
        lv[0] = 1'b1;
        ld[0] = 8'h01;
        @(negedge clk);
        lv[0] = 1'b0;
        foreach (exp_q[i]) begin
            got = {sf[0], sd[0], dn[0], lr[0]};
            n_checks++;
            if (got !== exp_q[i]) begin
                n_fail++;
                $display("FAIL midframe_reload[%0d]: sf/sd/dn/lr=%b expected %b", i, got, exp_q[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        obs_t got;
        int   frames;
        exp_q.delete();
        model_frame(8'h00, 1'b0);
        model_frame(8'hFF, 1'b0);
        lv[0] = 1'b1;
        ld[0] = 8'h00;
        frames = 0;
        @(negedge clk);
        foreach (exp_q[i]) begin
            got = {sf[0], sd[0], dn[0], lr[0]};
            n_checks++;
            if (got !== exp_q[i]) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: sf/sd/dn/lr=%b expected %b", i, got, exp_q[i]);
            end
            if (exp_q[i].lr) begin
                frames++;
                if (frames == 1) ld[0] = 8'hFF;
                else             lv[0] = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random;
        obs_t             got;
        int               sel;
        logic [WIDTH-1:0] d;
        for (int n = 0; n < 16; n++) begin
            sel = int'($urandom_range(1, 0));
            d   = WIDTH'($urandom);
            exp_q.delete();
            model_frame(d, sel == 1);
            lv[sel] = 1'b1;
            ld[sel] = d;
            @(negedge clk);
            lv[sel] = 1'b0;
            ld[sel] = WIDTH'($urandom);
            foreach (exp_q[i]) begin
                got = {sf[sel], sd[sel], dn[sel], lr[sel]};
                n_checks++;
                if (got !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL random n%0d dut%0d d=%h [%0d]: sf/sd/dn/lr=%b expected %b", n, sel, d, i, got, exp_q[i]);
                end
                @(negedge clk);
            end
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_parity();
        test_busy();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word via a valid/ready handshake and shifts it out LSB-first on a single data line, with a framing strobe and an optional even-parity bit. It drives the serial side that the team's registered single-bit capture stages sample, and it pulses a completion flag when the frame ends.

## Interface
- WIDTH, 8, data word width; must be at least 2.
- PARITY_EN, 0, when 1, appends one even-parity bit after the data bits.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- load_valid  input  1  load_data is valid this cycle.
- load_data  input  WIDTH  word to transmit; sampled only on accept.
- load_ready  output  1  block can accept a word (high only in IDLE).
- sdata  output  1  serial data bit, registered.
- sframe  output  1  high during every data and parity bit cycle, registered.
- done  output  1  one-cycle pulse after the last bit of a frame, registered.

## Operation
- States: IDLE, SHIFT, PARITY (only when PARITY_EN=1), DONE.
- Accept occurs at a rising edge where load_valid=1 and load_ready=1. On accept:
  - load_data is copied into the shift register.
  - The bit counter is cleared.
  - The even parity (XOR of all load_data bits) is captured.
  - The state moves to SHIFT.
- IDLE: load_ready=1, sframe=0, sdata=0, done=0.
- SHIFT: sframe=1 and sdata=current bit, starting with bit 0. The counter runs 0 to WIDTH-1. After bit WIDTH-1 the state moves to PARITY if PARITY_EN=1, otherwise to DONE.
- PARITY: sframe=1, sdata=captured parity, then the state moves to DONE.
- DONE: sframe=0, sdata=0, done=1, load_ready=0. Next state is always IDLE.
- load_ready is 0 in SHIFT, PARITY and DONE. load_valid in those states is ignored and no word is queued.
- Changes to load_data after accept have no effect on the frame in flight.
- Counter width is clog2(WIDTH). The counter never wraps mid-frame, and the terminal compare is against WIDTH-1.

## Timing
- Reset (rst=1, asynchronous): state=IDLE, sdata=0, sframe=0, done=0, counter=0, shift register=0. load_ready=0 while rst is high. load_valid during reset is ignored.
- Reset deassertion: load_ready=1 in the first cycle after rst falls.
- For an accept at edge k:
  - sframe=1 and sdata=load_data[i] in the cycle following edge k+i, for i=0..WIDTH-1.
  - If PARITY_EN=1: the parity bit occupies the cycle following edge k+WIDTH.
  - The done pulse occupies the next cycle. IDLE (load_ready=1) follows the cycle after that.
- Frame period: the earliest back-to-back accepts are WIDTH+PARITY_EN+2 cycles apart.
- Reset mid-frame: the frame aborts immediately. sframe=0 and sdata=0 asynchronously, done is not pulsed, and the state returns to IDLE after release.
- sframe and done are never high in the same cycle. done is never high for 2 consecutive cycles.

## Test plan
- Reset check: assert rst with load_valid=1 → sdata=0, sframe=0, done=0, load_ready=0. After release → load_ready=1 on the next cycle and no frame starts.
- Single frame, WIDTH=8, PARITY_EN=0, load 0xA5 → sdata sequence 1,0,1,0,0,1,0,1 with sframe=1 for exactly 8 cycles. Then done=1 for 1 cycle, then load_ready=1.
- Parity, PARITY_EN=1:
  - Load 0x07 → 8 data bits 1,1,1,0,0,0,0,0, then parity bit 1, 9 sframe cycles, then done.
  - Load 0xA5 → parity bit 0.
- Busy handling: hold load_valid=1 with load_data changing every cycle during a 0x3C frame → the output is exactly 0x3C. The next word is accepted only in IDLE, and the frame period is 10 cycles with PARITY_EN=0.
- Reset mid-frame: assert rst after bit 3 of 0xFF → sframe and sdata drop to 0 without waiting for a clock edge and no done pulse follows. After release, a new load of 0x01 transmits 1,0,0,0,0,0,0,0 correctly.
- Back-to-back: 0x00 then 0xFF with load_valid always high → two complete frames separated only by the DONE and IDLE cycles, with done pulsing once per frame.
